dff_sem_rst: RTL and testbench
==============================

Name: dff_sem_rst

Overview:
- Parameterized edge-triggered D flip-flop bank with true output `q` and complementary output `qn`.
- Captures `d` on the rising edge of `clk`. A synchronous active-high reset forces a known state.
- A load enable gates capture.
- Serves as a generic storage and retiming primitive for datapath and control registers throughout the design.

Parameters:
- WIDTH, 1: number of bits stored. Must be ≥ 1.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into `q` by reset.
- SYNC_STAGES, 2: depth of the optional input synchronizer chain. Used only when DFF_SEM_RST_SYNC_EN is defined; must be ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- d    input  WIDTH  data to capture.
- en   input  1  load enable, active-high. Tie to 1 for plain DFF behaviour.
- q    output WIDTH  registered data.
- qn   output WIDTH  bitwise complement of `q`.

Behaviour:
- Reset:
  - On a rising `clk` with `rst`=1: `q` <= RESET_VALUE and `qn` = ~RESET_VALUE.
  - Any synchronizer stages are cleared to RESET_VALUE.
  - `rst` overrides `en`.
  - Asserting `rst` between edges has no effect until the next rising edge.
- Capture: on a rising `clk` with `rst`=0 and `en`=1, `q` <= `d`. Latency is 1 cycle: a value present at edge N is visible on `q` right after edge N.
- Hold: on a rising `clk` with `rst`=0 and `en`=0, `q` keeps its value.
- `qn`:
  - Derived combinationally as ~`q`, so it never disagrees with `q`.
  - Must not be a separately registered copy.
- `d` changes between edges have no effect on `q`. No combinational path from `d` or `en` to `q`/`qn`.
- Before the first reset, `q` is undefined (X in simulation). No initial-value reliance.
- Simultaneous `d` change and clock edge: the value sampled at the edge (pre-edge value) is captured.
- All bits are independent; WIDTH=1 must behave as a single scalar flop.

Optional Feature:
- Macro: DFF_SEM_RST_SYNC_EN.
- Defined:
  - `d` first passes through a SYNC_STAGES-deep chain of flops clocked by `clk`. The chain shifts every cycle regardless of `en`.
  - The output register loads the last chain stage when `en`=1.
  - Latency from `d` to `q` is SYNC_STAGES+1 cycles.
  - Reset clears the whole chain.
  - Intended for asynchronous single-bit inputs; each bit is synchronized independently.
- Not defined: no chain, 1-cycle latency as above. SYNC_STAGES is ignored.

Decomposition:
- Shared package dff_pkg holds:
  - the default width constant (DFF_DEFAULT_WIDTH = 1);
  - the minimum synchronizer depth constant (DFF_MIN_SYNC_STAGES = 2).
- One natural sub-module: dff_sync_chain, a WIDTH × SYNC_STAGES shift chain with synchronous reset. It is instantiated only under DFF_SEM_RST_SYNC_EN.
- The top contains the enable/reset register and the `qn` inverter.

Test Plan:
- Reset:
  - WIDTH=1, RESET_VALUE=0, clk period 2 time units.
  - `rst`=1 for 2 edges with `d`=1 → `q`=0 and `qn`=1 after the first edge.
  - `rst`=1 with RESET_VALUE=1 → `q`=1, `qn`=0.
- Capture sequence:
  - `rst`=0, `en`=1, `d` = 0, 0, 1, 1, 0, 1 changed every 2 time units, with clock edges at odd times.
  - `q` follows `d` one edge later: 0, 0, 1, 1, 0, 1. `qn` is always the complement.
- Hold: `q`=1, then `en`=0 and `d`=0 for 3 edges → `q` stays 1 and `qn` stays 0. Re-enable → `q`=0 on the next edge.
- Reset priority: `q`=1, `en`=1, `d`=1, `rst`=1 for one edge → `q`=0. Release `rst` → `q`=1 on the following edge.
- Width:
  - WIDTH=8, `d`=8'hA5 → `q`=8'hA5 and `qn`=8'h5A after 1 edge.
  - `d`=8'hFF → `q`=8'hFF and `qn`=8'h00.
- Sync option: with DFF_SEM_RST_SYNC_EN defined and SYNC_STAGES=2, a step of `d` from 0 to 1 reaches `q` exactly 3 edges later. Without the macro, the same step reaches `q` in 1 edge.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared constants for the dff_sem_rst flop bank and its optional synchronizer.
package dff_pkg;

  localparam int unsigned DFF_DEFAULT_WIDTH   = 1;
  localparam int unsigned DFF_MIN_SYNC_STAGES = 2;

endpackage : dff_pkg

// File: rtl/dff_sync_chain.sv
// WIDTH x STAGES shift chain with synchronous reset; each bit is synchronized independently.
module dff_sync_chain
  import dff_pkg::*;
#(
  parameter int unsigned            WIDTH       = DFF_DEFAULT_WIDTH,
  parameter int unsigned            STAGES      = DFF_MIN_SYNC_STAGES,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES < DFF_MIN_SYNC_STAGES) begin : g_bad_depth
    $error("dff_sync_chain: STAGES must be >= %0d", DFF_MIN_SYNC_STAGES);
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  // Chain shifts every cycle; enable is applied only at the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule : dff_sync_chain

// File: rtl/dff_sem_rst.sv
// Enabled D flop bank with synchronous active-high reset and complementary output.
// Optional input synchronizer chain enabled by defining DFF_SEM_RST_SYNC_EN.
module dff_sem_rst
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      SYNC_STAGES = DFF_MIN_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_sem_rst: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

`ifdef DFF_SEM_RST_SYNC_EN
  dff_sync_chain #(
    .WIDTH       (WIDTH),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (d),
    .q_o (cap_d)
  );
`else
  assign cap_d = d;
`endif

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = cap_d;
    end
  end

  // Reset takes priority over the load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // qn is a pure inverter on q so the pair can never disagree.
  assign q  = q_q;
  assign qn = ~q_q;

endmodule : dff_sem_rst

// File: tb/tb_dff_sem_rst.sv
// Self-checking bench for dff_sem_rst: three instances (1-bit RV=0, 1-bit RV=1, 8-bit)
// checked against a delay-line reference model; honours DFF_SEM_RST_SYNC_EN.
module tb_dff_sem_rst;

  localparam int unsigned SYNC = 2;
`ifdef DFF_SEM_RST_SYNC_EN
  localparam int unsigned S = SYNC;
`else
  localparam int unsigned S = 0;
`endif
  localparam int unsigned LAT = S + 1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] d8;

  logic       q_a, qn_a, q_b, qn_b;
  logic [7:0] q_w, qn_w;

  dff_sem_rst #(.WIDTH(1), .RESET_VALUE(1'b0), .SYNC_STAGES(SYNC)) u_a (
    .clk(clk), .rst(rst), .d(d8[0]), .en(en), .q(q_a), .qn(qn_a));
  dff_sem_rst #(.WIDTH(1), .RESET_VALUE(1'b1), .SYNC_STAGES(SYNC)) u_b (
    .clk(clk), .rst(rst), .d(d8[0]), .en(en), .q(q_b), .qn(qn_b));
  dff_sem_rst #(.WIDTH(8), .RESET_VALUE(8'h00), .SYNC_STAGES(SYNC)) u_w (
    .clk(clk), .rst(rst), .d(d8), .en(en), .q(q_w), .qn(qn_w));

  logic [7:0] obs_q  [3];
  logic [7:0] obs_qn [3];
  assign obs_q[0]  = {7'b0, q_a};
  assign obs_qn[0] = {7'b0, qn_a};
  assign obs_q[1]  = {7'b0, q_b};
  assign obs_qn[1] = {7'b0, qn_b};
  assign obs_q[2]  = q_w;
  assign obs_qn[2] = qn_w;

  int n_cmp;
  int n_err;

  // Reference model: per-instance output value plus history of sampled d.
  logic [7:0] m_q  [3];
  logic [7:0] hist [3][8];

  function automatic logic [7:0] mask_of(input int k);
    return (k == 2) ? 8'hFF : 8'h01;
  endfunction

  function automatic logic [7:0] rv_of(input int k);
    return (k == 1) ? 8'h01 : 8'h00;
  endfunction

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] dv;
      logic [7:0] tap;
      dv  = d8 & mask_of(k);
      tap = (S == 0) ? dv : hist[k][S-1];
      for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = dv;
      if (rst) begin
        m_q[k] = rv_of(k);
        for (int i = 0; i < 8; i++) hist[k][i] = rv_of(k);
      end else if (en) begin
        m_q[k] = tap;
      end
    end
  endtask

  // Drive at the falling edge, let one rising edge occur, return at the next falling edge.
  task automatic cycle(input logic r, input logic e, input logic [7:0] dv);
    rst = r;
    en  = e;
    d8  = dv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 8'hFF);
    n_cmp++;
    if (q_a !== 1'b0 || qn_a !== 1'b1) begin
      n_err++;
      $display("FAIL reset_edge1_rv0: q=%b qn=%b want q=0 qn=1", q_a, qn_a);
    end
    n_cmp++;
    if (q_b !== 1'b1 || qn_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_edge1_rv1: q=%b qn=%b want q=1 qn=0", q_b, qn_b);
    end
    cycle(1'b1, 1'b1, 8'hFF);
    n_cmp++;
    if (q_a !== 1'b0 || qn_a !== 1'b1 || q_w !== 8'h00 || qn_w !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_edge2: q_a=%b qn_a=%b q_w=%h qn_w=%h want 0 1 00 ff",
               q_a, qn_a, q_w, qn_w);
    end
  endtask

  task automatic test_capture();
    logic [5:0] seq;
    seq = 6'b101100;  // applied LSB first: 0,0,1,1,0,1
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, {7'b0, seq[i]});
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_q[k] !== m_q[k] || obs_qn[k] !== (~m_q[k] & 8'h01)) begin
          n_err++;
          $display("FAIL capture[%0d] inst%0d: q=%h qn=%h want q=%h", i, k,
                   obs_q[k], obs_qn[k], m_q[k]);
        end
      end
    end
    if (S == 0) begin
      n_cmp++;
      if (q_a !== seq[5]) begin
        n_err++;
        $display("FAIL capture_last: q=%b want %b", q_a, seq[5]);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < int'(LAT); i++) cycle(1'b0, 1'b1, 8'h01);
    n_cmp++;
    if (q_a !== 1'b1) begin
      n_err++;
      $display("FAIL hold_setup: q=%b want 1", q_a);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (q_a !== 1'b1 || qn_a !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: q=%b qn=%b want q=1 qn=0", i, q_a, qn_a);
      end
    end
    cycle(1'b0, 1'b1, 8'h00);
    n_cmp++;
    if (q_a !== m_q[0][0] || (S == 0 && q_a !== 1'b0)) begin
      n_err++;
      $display("FAIL hold_reenable: q=%b want %b", q_a, m_q[0][0]);
    end
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < int'(LAT); i++) cycle(1'b0, 1'b1, 8'h01);
    cycle(1'b1, 1'b1, 8'h01);
    n_cmp++;
    if (q_a !== 1'b0 || qn_a !== 1'b1) begin
      n_err++;
      $display("FAIL rst_over_en: q=%b qn=%b want q=0 qn=1", q_a, qn_a);
    end
    cycle(1'b0, 1'b1, 8'h01);
    n_cmp++;
    if (q_a !== m_q[0][0] || (S == 0 && q_a !== 1'b1)) begin
      n_err++;
      $display("FAIL rst_release: q=%b want %b", q_a, m_q[0][0]);
    end
  endtask

  task automatic test_width();
    logic [7:0] pats [2];
    pats[0] = 8'hA5;
    pats[1] = 8'hFF;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < int'(LAT); i++) cycle(1'b0, 1'b1, pats[p]);
      n_cmp++;
      if (q_w !== pats[p] || qn_w !== ~pats[p]) begin
        n_err++;
        $display("FAIL width_%h: q=%h qn=%h want q=%h qn=%h", pats[p], q_w, qn_w,
                 pats[p], ~pats[p]);
      end
    end
  endtask

  task automatic test_latency();
    int edges;
    bool_loop : begin end
    cycle(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < int'(LAT) + 1; i++) cycle(1'b0, 1'b1, 8'h00);
    edges = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, 8'h01);
      if (q_a === 1'b1) begin
        edges = i;
        break;
      end
    end
    n_cmp++;
    if (edges != int'(LAT)) begin
      n_err++;
      $display("FAIL step_latency: edges=%0d want %0d (0 = not seen in 10)", edges, LAT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(15) == 0), ($urandom_range(3) != 0), 8'($urandom));
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_q[k] !== m_q[k] || obs_qn[k] !== (~m_q[k] & mask_of(k))) begin
          n_err++;
          $display("FAIL random[%0d] inst%0d: q=%h qn=%h want q=%h", i, k,
                   obs_q[k], obs_qn[k], m_q[k]);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    en    = 1'b0;
    d8    = 8'h00;
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 8'hxx;
      for (int i = 0; i < 8; i++) hist[k][i] = 8'hxx;
    end
    @(negedge clk);
    test_reset();
    test_capture();
    test_hold();
    test_reset_priority();
    test_width();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dff_sem_rst
